// File: rtl/producer.sv
//------------------------------------------------------------------------------
//  Module   : producer
//  Purpose  : Write-side pointer and full-flag logic of a dual-clock FIFO.
//             Keeps the binary/Gray write pointers and brings the read
//             domain's Gray pointer in through a two-flop synchroniser.
//             From these it derives registered full, almost_full and a
//             conservative fill level.
//  Ports    : clk            - write-domain clock
//             w_rst          - synchronous active-high reset
//             w_en           - write request
//             gray_rptr      - Gray read pointer (asynchronous to clk)
//             full           - registered full flag
//             almost_full    - registered level >= AFULL_THRESH
//             level          - registered fill count (may overstate)
//             binary_wptr    - binary write pointer (low bits address RAM)
//             gray_wptr      - Gray write pointer (crosses to read domain)
//             gray_rptrsync  - second synchroniser stage of gray_rptr
//             overflow       - sticky write-while-full flag
//  Options  : PRODUCER_OVERFLOW_EN - when defined, builds the sticky
//             overflow register; otherwise overflow is tied to 0.
//  Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module producer #(
    parameter int ADDR_WIDTH   = 9,
    parameter int AFULL_THRESH = (1 << ADDR_WIDTH) - 4
) (
    input  logic                  clk,
    input  logic                  w_rst,
    input  logic                  w_en,
    input  logic [ADDR_WIDTH:0]   gray_rptr,
    output logic                  full,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   level,
    output logic [ADDR_WIDTH:0]   binary_wptr,
    output logic [ADDR_WIDTH:0]   gray_wptr,
    output logic [ADDR_WIDTH:0]   gray_rptrsync,
    output logic                  overflow
);

    localparam logic [ADDR_WIDTH:0] c_afull_thresh = AFULL_THRESH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] c_zero         = '0;

    // Registered state
    logic [ADDR_WIDTH:0] r_rptr_s1;
    logic [ADDR_WIDTH:0] r_rptr_sync;
    logic [ADDR_WIDTH:0] r_bin_wptr;
    logic [ADDR_WIDTH:0] r_gray_wptr;
    logic [ADDR_WIDTH:0] r_level;
    logic                r_full;
    logic                r_almost_full;

    // Next-state terms
    logic                w_accept;
    logic [ADDR_WIDTH:0] w_bin_nxt;
    logic [ADDR_WIDTH:0] w_gray_nxt;
    logic [ADDR_WIDTH:0] w_full_cmp;
    logic [ADDR_WIDTH:0] w_rbin;
    logic [ADDR_WIDTH:0] w_level_nxt;
    logic                w_full_nxt;
    logic                w_afull_nxt;

    // Only the registered full gates the write, so there is no path from
    // full back into itself within a cycle.
    assign w_accept   = w_en & ~r_full;
    assign w_bin_nxt  = r_bin_wptr + {c_zero[ADDR_WIDTH:1], w_accept};
    assign w_gray_nxt = (w_bin_nxt >> 1) ^ w_bin_nxt;

    // The write pointer is exactly one lap ahead of the read pointer when
    // the two Gray MSBs differ and all lower bits match.
    assign w_full_cmp = {~r_rptr_sync[ADDR_WIDTH:ADDR_WIDTH-1],
                         r_rptr_sync[ADDR_WIDTH-2:0]};
    assign w_full_nxt = (w_gray_nxt == w_full_cmp);

    // Gray-to-binary: each binary bit is the XOR of all Gray bits at or
    // above its position.
    generate
        for (genvar i = 0; i <= ADDR_WIDTH; i++) begin : g_gray2bin
            assign w_rbin[i] = ^r_rptr_sync[ADDR_WIDTH:i];
        end
    endgenerate

    // The synced read pointer lags the real one, so this difference can only
    // overstate occupancy, never understate it.
    assign w_level_nxt = w_bin_nxt - w_rbin;
    assign w_afull_nxt = (w_level_nxt >= c_afull_thresh);

    always_ff @(posedge clk) begin
        if (w_rst) begin
            r_rptr_s1     <= '0;
            r_rptr_sync   <= '0;
            r_bin_wptr    <= '0;
            r_gray_wptr   <= '0;
            r_level       <= '0;
            r_full        <= 1'b0;
            r_almost_full <= 1'b0;
        end else begin
            // Two-flop synchroniser: nothing may sit between the stages.
            r_rptr_s1     <= gray_rptr;
            r_rptr_sync   <= r_rptr_s1;
            r_bin_wptr    <= w_bin_nxt;
            r_gray_wptr   <= w_gray_nxt;
            r_level       <= w_level_nxt;
            r_full        <= w_full_nxt;
            r_almost_full <= w_afull_nxt;
        end
    end

`ifdef PRODUCER_OVERFLOW_EN
    logic r_overflow;

    // Sticky until reset; an accepted write can never set it because it
    // requires the registered full to be high.
    always_ff @(posedge clk) begin
        if (w_rst) begin
            r_overflow <= 1'b0;
        end else if (w_en && r_full) begin
            r_overflow <= 1'b1;
        end
    end

    assign overflow = r_overflow;
`else
    assign overflow = 1'b0;
`endif

    assign full          = r_full;
    assign almost_full   = r_almost_full;
    assign level         = r_level;
    assign binary_wptr   = r_bin_wptr;
    assign gray_wptr     = r_gray_wptr;
    assign gray_rptrsync = r_rptr_sync;

endmodule

`default_nettype wire

// File: tb/tb_producer.sv
//------------------------------------------------------------------------------
//  Module   : tb_producer
//  Purpose  : Directed self-checking bench for producer with ADDR_WIDTH=2,
//             AFULL_THRESH=3. Expected values are hand-derived constants.
//  Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_producer;

    localparam int AW = 2;

`ifdef PRODUCER_OVERFLOW_EN
    localparam logic OVF_EN = 1'b1;
`else
    localparam logic OVF_EN = 1'b0;
`endif

    logic          clk;
    logic          w_rst;
    logic          w_en;
    logic [AW:0]   gray_rptr;
    logic          full;
    logic          almost_full;
    logic [AW:0]   level;
    logic [AW:0]   binary_wptr;
    logic [AW:0]   gray_wptr;
    logic [AW:0]   gray_rptrsync;
    logic          overflow;

    int errors = 0;
    int checks = 0;

    producer #(
        .ADDR_WIDTH   (AW),
        .AFULL_THRESH (3)
    ) dut (
        .clk           (clk),
        .w_rst         (w_rst),
        .w_en          (w_en),
        .gray_rptr     (gray_rptr),
        .full          (full),
        .almost_full   (almost_full),
        .level         (level),
        .binary_wptr   (binary_wptr),
        .gray_wptr     (gray_wptr),
        .gray_rptrsync (gray_rptrsync),
        .overflow      (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input int bin, input int gry,
                             input int lvl, input int fl, input int af,
                             input int ovf);
        check({tag, ".binary_wptr"}, int'(binary_wptr), bin);
        check({tag, ".gray_wptr"},   int'(gray_wptr),   gry);
        check({tag, ".level"},       int'(level),       lvl);
        check({tag, ".full"},        int'(full),        fl);
        check({tag, ".almost_full"}, int'(almost_full), af);
        check({tag, ".overflow"},    int'(overflow),    ovf);
    endtask

    initial begin
        w_rst     = 1'b1;
        w_en      = 1'b1;
        gray_rptr = 3'd5;

        // Reset held for two edges with a write and a nonzero read pointer.
        step();
        check_all("rst0", 0, 0, 0, 0, 0, 0);
        check("rst0.gray_rptrsync", int'(gray_rptrsync), 0);
        step();
        check_all("rst1", 0, 0, 0, 0, 0, 0);
        check("rst1.gray_rptrsync", int'(gray_rptrsync), 0);

        // Fill four slots.
        w_rst     = 1'b0;
        gray_rptr = 3'd0;
        w_en      = 1'b1;
        step(); check_all("fill1", 1, 1, 1, 0, 0, 0);
        step(); check_all("fill2", 2, 3, 2, 0, 0, 0);
        step(); check_all("fill3", 3, 2, 3, 0, 1, 0);
        step(); check_all("fill4", 4, 6, 4, 1, 1, 0);

        // Write while full is dropped.
        step(); check_all("ovf1", 4, 6, 4, 1, 1, int'(OVF_EN));
        w_en = 1'b0;
        step(); check_all("ovf2", 4, 6, 4, 1, 1, int'(OVF_EN));

        // Release one slot from the read side: visible on the third edge.
        gray_rptr = 3'd1;
        step(); check_all("rel1", 4, 6, 4, 1, 1, int'(OVF_EN));
        step(); check_all("rel2", 4, 6, 4, 1, 1, int'(OVF_EN));
        check("rel2.gray_rptrsync", int'(gray_rptrsync), 1);
        step(); check_all("rel3", 4, 6, 3, 0, 1, int'(OVF_EN));
        w_en = 1'b1;
        step(); check_all("rel4", 5, 7, 4, 1, 1, int'(OVF_EN));

        // Wrap: read pointer walks 3, 2, 6 while writing continuously.
        gray_rptr = 3'd3;
        step(); check_all("wrapA", 5, 7, 4, 1, 1, int'(OVF_EN));
        gray_rptr = 3'd2;
        step(); check_all("wrapB", 5, 7, 4, 1, 1, int'(OVF_EN));
        gray_rptr = 3'd6;
        step(); check_all("wrapC", 5, 7, 3, 0, 1, int'(OVF_EN));
        step(); check_all("wrapD", 6, 5, 3, 0, 1, int'(OVF_EN));
        check("wrapD.gray_rptrsync", int'(gray_rptrsync), 6);
        step(); check_all("wrapE", 7, 4, 3, 0, 1, int'(OVF_EN));
        step(); check_all("wrapF", 0, 0, 4, 1, 1, int'(OVF_EN));
        step(); check_all("wrapG", 0, 0, 4, 1, 1, int'(OVF_EN));

        // Bring level down to 2: read pointer at binary 6 (Gray 5).
        w_en      = 1'b0;
        gray_rptr = 3'd5;
        step();
        step();
        step(); check_all("lvl2", 0, 0, 2, 0, 0, int'(OVF_EN));

        // Mid-operation reset with a write pending.
        w_rst = 1'b1;
        w_en  = 1'b1;
        step(); check_all("mrst", 0, 0, 0, 0, 0, 0);
        check("mrst.gray_rptrsync", int'(gray_rptrsync), 0);

        // First write after reset release.
        w_rst     = 1'b0;
        gray_rptr = 3'd0;
        step(); check_all("post", 1, 1, 1, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
